bpu_pht_ctrl: RTL and testbench

Controller and client of the branch predictor's dual-port pattern history table (PHT) RAM. It clears the table after reset and serves single-cycle prediction lookups on RAM port A. It applies branch-resolution updates to 2-bit saturating counters as a read-modify-write on port B. It sits between the fetch-stage predictor logic and the PHT storage array.

---
 rtl/bpu_pkg.sv | 34 +++
 rtl/bpu_pht_ram.sv | 47 ++++
 rtl/bpu_pht_ctrl.sv | 156 +++++++++++++++
 tb/tb_bpu_pht_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
// Shared types and helpers for the branch predictor's pattern history table.
package bpu_pkg;

  // Counter value written into every entry by the post-reset clear (weakly not-taken).
  localparam int CNT_INIT = 1;

  // Widest counter the shared update helper can handle.
  localparam int CNT_MAX_W = 8;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    RD,
    WR
  } pht_state_e;

  // Saturating step of a direction counter toward the resolved outcome.
  // cnt_max is the counter's all-ones value; the default suits 2-bit counters.
  function automatic logic [CNT_MAX_W-1:0] sat_update(
    input logic [CNT_MAX_W-1:0] cnt,
    input logic                 taken,
    input logic [CNT_MAX_W-1:0] cnt_max = CNT_MAX_W'(3)
  );
    logic [CNT_MAX_W-1:0] res;
    res = cnt;
    if (taken) begin
      if (cnt != cnt_max) res = cnt + CNT_MAX_W'(1);
    end else begin
      if (cnt != '0) res = cnt - CNT_MAX_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/bpu_pht_ram.sv
// True dual-port PHT storage: synchronous 1-cycle reads, read-old-data on a
// same-port write, and read data forced to zero when a port is idle or in reset.
module bpu_pht_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena_i,
  input  logic                  wea_i,
  input  logic [ADDR_WIDTH-1:0] addra_i,
  input  logic [DATA_WIDTH-1:0] dina_i,
  output logic [DATA_WIDTH-1:0] douta_o,
  input  logic                  enb_i,
  input  logic                  web_i,
  input  logic [ADDR_WIDTH-1:0] addrb_i,
  input  logic [DATA_WIDTH-1:0] dinb_i,
  output logic [DATA_WIDTH-1:0] doutb_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] douta_q;
  logic [DATA_WIDTH-1:0] doutb_q;

  // Both write ports share one process so the array has a single driver; port B wins a collision.
  always_ff @(posedge clk) begin
    if (ena_i && wea_i) mem_q[addra_i] <= dina_i;
    if (enb_i && web_i) mem_q[addrb_i] <= dinb_i;
  end

  // Registered reads sample the array before this edge's writes land, giving old data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      douta_q <= '0;
      doutb_q <= '0;
    end else begin
      douta_q <= ena_i ? mem_q[addra_i] : '0;
      doutb_q <= enb_i ? mem_q[addrb_i] : '0;
    end
  end

  assign douta_o = douta_q;
  assign doutb_o = doutb_q;

endmodule

// File: rtl/bpu_pht_ctrl.sv
// PHT controller: clears the table after reset, serves lookups on port A and
// applies saturating counter updates as a read-modify-write on port B.
module bpu_pht_ctrl
  import bpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pred_req_i,
  input  logic [ADDR_WIDTH-1:0] pred_idx_i,
  output logic                  pred_valid_o,
  output logic                  pred_taken_o,
  output logic [CNT_WIDTH-1:0]  pred_cnt_o,
  input  logic                  upd_valid_i,
  input  logic [ADDR_WIDTH-1:0] upd_idx_i,
  input  logic                  upd_taken_i,
  output logic                  upd_ready_o,
  output logic                  init_done_o
);

  localparam logic [CNT_WIDTH-1:0] CntInitVal = CNT_WIDTH'(CNT_INIT);
  localparam logic [CNT_MAX_W-1:0] CntMaxExt  = CNT_MAX_W'((1 << CNT_WIDTH) - 1);

  pht_state_e            state_q;
  logic [ADDR_WIDTH-1:0] sweep_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic                  taken_q;
  logic [CNT_WIDTH-1:0]  wdata_q;
  logic                  upd_ready_q;
  logic                  init_done_q;
  logic                  pred_valid_q;
  logic                  fwd_valid_q;
  logic [CNT_WIDTH-1:0]  fwd_data_q;

  logic                  handshake;
  logic                  ena;
  logic [CNT_WIDTH-1:0]  douta;
  logic                  enb_d;
  logic                  web_d;
  logic [ADDR_WIDTH-1:0] addrb_d;
  logic [CNT_WIDTH-1:0]  dinb_d;
  logic [CNT_WIDTH-1:0]  doutb;
  logic [CNT_WIDTH-1:0]  upd_next_d;

  assign handshake  = upd_valid_i & upd_ready_q;
  assign ena        = pred_req_i & init_done_q;
  assign upd_next_d = CNT_WIDTH'(sat_update(CNT_MAX_W'(doutb), taken_q, CntMaxExt));

  // Port B control follows the FSM state; gated by rst_n so a reset cycle never writes.
  always_comb begin
    enb_d   = 1'b0;
    web_d   = 1'b0;
    addrb_d = sweep_q;
    dinb_d  = CntInitVal;
    case (state_q)
      INIT: begin
        enb_d   = rst_n;
        web_d   = rst_n;
        addrb_d = sweep_q;
        dinb_d  = CntInitVal;
      end
      IDLE: begin
        enb_d   = rst_n & handshake;
        addrb_d = upd_idx_i;
      end
      WR: begin
        enb_d   = rst_n;
        web_d   = rst_n;
        addrb_d = idx_q;
        dinb_d  = wdata_q;
      end
      default: ;
    endcase
  end

  // Clear sweep and update sequencer with registered ready/done outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= INIT;
      sweep_q     <= '0;
      idx_q       <= '0;
      taken_q     <= 1'b0;
      wdata_q     <= '0;
      upd_ready_q <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          sweep_q <= sweep_q + ADDR_WIDTH'(1);
          if (sweep_q == '1) begin
            state_q     <= IDLE;
            upd_ready_q <= 1'b1;
            init_done_q <= 1'b1;
          end
        end
        IDLE: begin
          if (handshake) begin
            idx_q       <= upd_idx_i;
            taken_q     <= upd_taken_i;
            upd_ready_q <= 1'b0;
            state_q     <= RD;
          end
        end
        RD: begin
          wdata_q <= upd_next_d;
          state_q <= WR;
        end
        WR: begin
          upd_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= INIT;
      endcase
    end
  end

  // Lookup valid and the bypass of a port-B write that lands on the same index this cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pred_valid_q <= 1'b0;
      fwd_valid_q  <= 1'b0;
      fwd_data_q   <= '0;
    end else begin
      pred_valid_q <= ena;
      fwd_valid_q  <= ena & web_d & (pred_idx_i == addrb_d);
      fwd_data_q   <= dinb_d;
    end
  end

  bpu_pht_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(CNT_WIDTH)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena_i  (ena),
    .wea_i  (1'b0),
    .addra_i(pred_idx_i),
    .dina_i ('0),
    .douta_o(douta),
    .enb_i  (enb_d),
    .web_i  (web_d),
    .addrb_i(addrb_d),
    .dinb_i (dinb_d),
    .doutb_o(doutb)
  );

  assign pred_valid_o = pred_valid_q;
  assign pred_cnt_o   = fwd_valid_q ? fwd_data_q : douta;
  assign pred_taken_o = pred_cnt_o[CNT_WIDTH-1];
  assign upd_ready_o  = upd_ready_q;
  assign init_done_o  = init_done_q;

endmodule

// File: tb/tb_bpu_pht_ctrl.sv
// Directed bench for the PHT controller with a 16-entry table of 2-bit counters.
module tb_bpu_pht_ctrl;

  localparam int AW = 4;
  localparam int CW = 2;

  logic          clk;
  logic          rst_n;
  logic          pred_req_i;
  logic [AW-1:0] pred_idx_i;
  logic          pred_valid_o;
  logic          pred_taken_o;
  logic [CW-1:0] pred_cnt_o;
  logic          upd_valid_i;
  logic [AW-1:0] upd_idx_i;
  logic          upd_taken_i;
  logic          upd_ready_o;
  logic          init_done_o;

  int compared   = 0;
  int mismatched = 0;

  logic [1:0] upExp   [4] = '{2'd2, 2'd3, 2'd3, 2'd3};
  logic [1:0] downExp [3] = '{2'd0, 2'd0, 2'd0};
  logic [1:0] fwdExp  [5] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
  logic [3:0] hsIdx   [3] = '{4'd10, 4'd11, 4'd12};
  logic       hsReady [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  bpu_pht_ctrl #(
    .ADDR_WIDTH(AW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pred_req_i  (pred_req_i),
    .pred_idx_i  (pred_idx_i),
    .pred_valid_o(pred_valid_o),
    .pred_taken_o(pred_taken_o),
    .pred_cnt_o  (pred_cnt_o),
    .upd_valid_i (upd_valid_i),
    .upd_idx_i   (upd_idx_i),
    .upd_taken_i (upd_taken_i),
    .upd_ready_o (upd_ready_o),
    .init_done_o (init_done_o)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so a stuck design still ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected run to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Expects the sweep to start in the current cycle; lookups offered meanwhile must be dropped.
  task automatic checkSweep();
    pred_req_i = 1'b1;
    for (int c = 0; c < 16; c++) begin
      pred_idx_i = 4'(c);
      checkOutput("sweep_init_done", 32'(init_done_o), 32'd0);
      checkOutput("sweep_ready", 32'(upd_ready_o), 32'd0);
      tick();
      checkOutput("sweep_pred_dropped", 32'(pred_valid_o), 32'd0);
    end
    pred_req_i = 1'b0;
    checkOutput("init_done_rise", 32'(init_done_o), 32'd1);
    checkOutput("ready_rise", 32'(upd_ready_o), 32'd1);
  endtask

  task automatic lookup(input logic [3:0] idx, input logic [1:0] expCnt, input string tag);
    pred_req_i = 1'b1;
    pred_idx_i = idx;
    tick();
    pred_req_i = 1'b0;
    checkOutput({tag, "_valid"}, 32'(pred_valid_o), 32'd1);
    checkOutput({tag, "_cnt"}, 32'(pred_cnt_o), 32'(expCnt));
    checkOutput({tag, "_taken"}, 32'(pred_taken_o), 32'(expCnt[1]));
  endtask

  // Back-to-back lookups of every entry, all expected to hold the cleared value.
  task automatic lookupAll(input string tag);
    pred_req_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      pred_idx_i = 4'(i);
      tick();
      checkOutput($sformatf("%s_valid_%0d", tag, i), 32'(pred_valid_o), 32'd1);
      checkOutput($sformatf("%s_cnt_%0d", tag, i), 32'(pred_cnt_o), 32'd1);
      checkOutput($sformatf("%s_taken_%0d", tag, i), 32'(pred_taken_o), 32'd0);
    end
    pred_req_i = 1'b0;
    tick();
    checkOutput({tag, "_valid_off"}, 32'(pred_valid_o), 32'd0);
  endtask

  // One complete update: bounded wait for ready, handshake, then ride out RD and WR.
  task automatic applyStimulus(input logic [3:0] idx, input logic taken);
    int waitCycles;
    waitCycles = 0;
    while (!upd_ready_o && waitCycles < 20) begin
      tick();
      waitCycles++;
    end
    checkOutput("upd_ready_wait", 32'(upd_ready_o), 32'd1);
    upd_valid_i = 1'b1;
    upd_idx_i   = idx;
    upd_taken_i = taken;
    tick();
    upd_valid_i = 1'b0;
    checkOutput("upd_ready_rd", 32'(upd_ready_o), 32'd0);
    tick();
    checkOutput("upd_ready_wr", 32'(upd_ready_o), 32'd0);
    tick();
  endtask

  // Main directed sequence.
  initial begin
    rst_n       = 1'b0;
    pred_req_i  = 1'b0;
    pred_idx_i  = '0;
    upd_valid_i = 1'b0;
    upd_idx_i   = '0;
    upd_taken_i = 1'b0;
    tick();
    tick();
    checkOutput("rst_pred_valid", 32'(pred_valid_o), 32'd0);
    checkOutput("rst_pred_taken", 32'(pred_taken_o), 32'd0);
    checkOutput("rst_pred_cnt", 32'(pred_cnt_o), 32'd0);
    checkOutput("rst_upd_ready", 32'(upd_ready_o), 32'd0);
    checkOutput("rst_init_done", 32'(init_done_o), 32'd0);

    rst_n = 1'b1;
    checkSweep();
    lookupAll("clear");

    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'd5, 1'b1);
      lookup(4'd5, upExp[k], $sformatf("sat_up_%0d", k));
    end

    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'd9, 1'b0);
      lookup(4'd9, downExp[k], $sformatf("sat_down_%0d", k));
    end

    checkOutput("fwd_start_ready", 32'(upd_ready_o), 32'd1);
    pred_req_i  = 1'b1;
    pred_idx_i  = 4'd7;
    upd_valid_i = 1'b1;
    upd_idx_i   = 4'd7;
    upd_taken_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      upd_valid_i = 1'b0;
      checkOutput($sformatf("fwd_valid_%0d", k), 32'(pred_valid_o), 32'd1);
      checkOutput($sformatf("fwd_cnt_%0d", k), 32'(pred_cnt_o), 32'(fwdExp[k]));
    end
    pred_req_i = 1'b0;

    for (int k = 0; k < 7; k++) begin
      upd_valid_i = 1'b1;
      upd_taken_i = 1'b1;
      upd_idx_i   = (k % 3 == 0) ? hsIdx[k / 3] : 4'd13;
      checkOutput($sformatf("hs_ready_%0d", k), 32'(upd_ready_o), 32'(hsReady[k]));
      tick();
    end
    upd_valid_i = 1'b0;
    tick();
    tick();
    lookup(4'd10, 2'd2, "hs_idx10");
    lookup(4'd11, 2'd2, "hs_idx11");
    lookup(4'd12, 2'd2, "hs_idx12");
    lookup(4'd13, 2'd1, "hs_idx13_not_applied");

    checkOutput("mid_rst_ready", 32'(upd_ready_o), 32'd1);
    upd_valid_i = 1'b1;
    upd_idx_i   = 4'd14;
    upd_taken_i = 1'b1;
    tick();
    upd_valid_i = 1'b0;
    checkOutput("mid_rst_in_rd", 32'(upd_ready_o), 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("mid_rst_init_done", 32'(init_done_o), 32'd0);
    checkSweep();
    lookupAll("reclear");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
